// File: rtl/bf16_add_sequencer_if.sv
// Handshake and adder-side signal bundle for bf16_add_sequencer.
// slave is the sequencer's view; master is the environment's view.
interface bf16_add_sequencer_if;
   logic        in_valid;
   logic [15:0] in_a;
   logic [15:0] in_b;
   logic        in_ready;
   logic [15:0] add_a;
   logic [15:0] add_b;
   logic        adder_ready;
   logic [15:0] adder_sum;
   logic        res_valid;
   logic [15:0] res_data;
   logic [7:0]  res_tag;
   logic        res_ready;
   logic        busy;

   modport slave (
      input  in_valid, in_a, in_b, adder_ready, adder_sum, res_ready,
      output in_ready, add_a, add_b, res_valid, res_data, res_tag, busy
   );

   modport master (
      output in_valid, in_a, in_b, adder_ready, adder_sum, res_ready,
      input  in_ready, add_a, add_b, res_valid, res_data, res_tag, busy
   );
endinterface

// File: rtl/bf16_add_sequencer.sv
// Operand FIFO feeding an external bf16 adder on its ready edges, with
// credit-gated issue into a tagged result FIFO.
module bf16_add_sequencer #(
   parameter int IN_DEPTH  = 4,
   parameter int OUT_DEPTH = 2
) (
   input logic                 clock,
   input logic                 nreset,
   bf16_add_sequencer_if.slave bus
);

   localparam int IPW = $clog2(IN_DEPTH);
   localparam int OPW = $clog2(OUT_DEPTH);
   localparam logic [IPW:0] IN_FULL  = (IPW+1)'(IN_DEPTH);
   localparam logic [OPW:0] OUT_FULL = (OPW+1)'(OUT_DEPTH);

   typedef enum logic {S_IDLE, S_INFLIGHT} state_t;

   state_t         state_q, state_d;
   logic           hist_q, hist_d;
   logic [IPW-1:0] iwp_q, iwp_d, irp_q, irp_d;
   logic [IPW:0]   icnt_q, icnt_d;
   logic [OPW-1:0] owp_q, owp_d, orp_q, orp_d;
   logic [OPW:0]   ocnt_q, ocnt_d;
   logic [7:0]     issue_q, issue_d, tag_q, tag_d;
   logic [15:0]    add_a_q, add_a_d, add_b_q, add_b_d;

   logic [15:0] ia_mem [IN_DEPTH];
   logic [15:0] ib_mem [IN_DEPTH];
   logic [23:0] o_mem  [OUT_DEPTH];

   logic         in_rdy, res_vld;
   logic         evt, push, issue, wr_res, pop_res;
   logic [OPW:0] ocnt_edge;

   assign in_rdy  = icnt_q < IN_FULL;
   assign res_vld = ocnt_q != '0;

   always_ff @(posedge clock or negedge nreset) begin
      if (!nreset) begin
         state_q <= S_IDLE;
         hist_q  <= 1'b1;
         iwp_q   <= '0;
         irp_q   <= '0;
         icnt_q  <= '0;
         owp_q   <= '0;
         orp_q   <= '0;
         ocnt_q  <= '0;
         issue_q <= '0;
         tag_q   <= '0;
         add_a_q <= '0;
         add_b_q <= '0;
      end else begin
         state_q <= state_d;
         hist_q  <= hist_d;
         iwp_q   <= iwp_d;
         irp_q   <= irp_d;
         icnt_q  <= icnt_d;
         owp_q   <= owp_d;
         orp_q   <= orp_d;
         ocnt_q  <= ocnt_d;
         issue_q <= issue_d;
         tag_q   <= tag_d;
         add_a_q <= add_a_d;
         add_b_q <= add_b_d;
      end
   end

   always_ff @(posedge clock) begin
      if (push) begin
         ia_mem[iwp_q] <= bus.in_a;
         ib_mem[iwp_q] <= bus.in_b;
      end
      if (wr_res) o_mem[owp_q] <= {bus.adder_sum, tag_q};
   end

   always_comb begin
      evt     = bus.adder_ready & ~hist_q;
      push    = bus.in_valid & in_rdy;
      pop_res = res_vld & bus.res_ready;
      wr_res  = evt & (state_q == S_INFLIGHT);
      // Reserve a result slot for the pair being issued before it leaves.
      ocnt_edge = ocnt_q + (OPW+1)'(wr_res) - (OPW+1)'(pop_res);
      issue     = evt & (icnt_q != '0) & (ocnt_edge < OUT_FULL);

      hist_d  = bus.adder_ready;
      state_d = state_q;
      add_a_d = add_a_q;
      add_b_d = add_b_q;
      tag_d   = tag_q;
      issue_d = issue_q;

      if (evt) begin
         if (issue) begin
            state_d = S_INFLIGHT;
            add_a_d = ia_mem[irp_q];
            add_b_d = ib_mem[irp_q];
            tag_d   = issue_q;
            issue_d = issue_q + 8'd1;
         end else begin
            state_d = S_IDLE;
            add_a_d = '0;
            add_b_d = '0;
         end
      end

      iwp_d  = push ? iwp_q + IPW'(1) : iwp_q;
      irp_d  = issue ? irp_q + IPW'(1) : irp_q;
      icnt_d = icnt_q + (IPW+1)'(push) - (IPW+1)'(issue);
      owp_d  = wr_res ? owp_q + OPW'(1) : owp_q;
      orp_d  = pop_res ? orp_q + OPW'(1) : orp_q;
      ocnt_d = ocnt_edge;
   end

   assign bus.in_ready  = in_rdy;
   assign bus.res_valid = res_vld;
   assign bus.res_data  = res_vld ? o_mem[orp_q][23:8] : '0;
   assign bus.res_tag   = res_vld ? o_mem[orp_q][7:0] : '0;
   assign bus.add_a     = add_a_q;
   assign bus.add_b     = add_b_q;
   assign bus.busy      = (state_q == S_INFLIGHT) | (icnt_q != '0) | res_vld;

endmodule

// File: doc/bf16_add_sequencer.md
BF16_ADD_SEQUENCER -- requirements
Module: bf16_add_sequencer

Interface
REQ-001 SHALL have parameter IN_DEPTH, default 4, operand-pair FIFO depth (power of 2, >=2).
REQ-002 SHALL have parameter OUT_DEPTH, default 2, result FIFO depth (power of 2, >=2).
REQ-003 SHALL have port clock  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port nreset  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port in_valid  input  1  operand pair offered.
REQ-006 SHALL have port in_a  input  16  bfloat16 operand A.
REQ-007 SHALL have port in_b  input  16  bfloat16 operand B.
REQ-008 SHALL have port in_ready  output  1  operand FIFO not full.
REQ-009 SHALL have port add_a  output  16  registered operand A to the adder's `a` input.
REQ-010 SHALL have port add_b  output  16  registered operand B to the adder's `b` input.
REQ-011 SHALL have port adder_ready  input  1  adder `ready` output.
REQ-012 SHALL have port adder_sum  input  16  adder `sum` output.
REQ-013 SHALL have port res_valid  output  1  result FIFO not empty.
REQ-014 SHALL have port res_data  output  16  head-of-FIFO sum.
REQ-015 SHALL have port res_tag  output  8  sequence number of head result.
REQ-016 SHALL have port res_ready  input  1  consumer accepts result.
REQ-017 SHALL have port busy  output  1  any pair queued, in flight, or result pending.

Function
REQ-018 SHALL accept a pair when in_valid && in_ready; SHALL raise in_ready exactly when the operand FIFO holds fewer than IN_DEPTH entries.
REQ-019 SHALL define the adder event as adder_ready high in a cycle where it was low the previous cycle; a level held high for several cycles SHALL count as one event.
REQ-020 SHALL hold add_a/add_b stable between events. The adder samples `a` one cycle after an event and `b` two cycles after it.
REQ-021 On an event, if inflight=1, SHALL write {adder_sum, inflight_tag} into the result FIFO in the same edge.
REQ-022 On an event, SHALL issue the operand FIFO head to add_a/add_b and set inflight=1, inflight_tag=issue_cnt, issue_cnt+=1 (mod 256), but only if both hold: the operand FIFO is non-empty, and result count after this edge plus 1 <= OUT_DEPTH.
REQ-023 On an event where the issue condition is false, SHALL set inflight=0 and drive add_a=add_b=16'h0000.
REQ-024 Credit rule REQ-022 SHALL guarantee the result FIFO never overflows; a write when full SHALL be impossible by construction.
REQ-025 Simultaneous operand push and issue-pop, and simultaneous result write and res_ready pop, SHALL both succeed with the count unchanged.
REQ-026 FIFO pointers SHALL wrap modulo depth; full and empty SHALL be derived from an explicit occupancy count.
REQ-027 SHALL produce results in issue order; res_tag SHALL increment by 1 per result, wrapping 255->0.
REQ-028 SHALL set busy = inflight | operand count!=0 | result count!=0.
REQ-029 res_data/res_tag SHALL remain stable while res_valid && !res_ready.
REQ-030 SHALL ignore in_valid when in_ready=0; no data change SHALL occur.

Reset
REQ-031 nreset low SHALL asynchronously clear: both FIFOs empty, inflight=0, issue_cnt=0, adder_ready history=1, add_a=add_b=0.
REQ-032 During and after reset SHALL output in_ready=1, res_valid=0, res_data=0, res_tag=0, busy=0.
REQ-033 History reset to 1 SHALL suppress an event when adder_ready is already high on the first cycle after reset; the first post-reset event (dummy adder result) SHALL be discarded because inflight=0.
REQ-034 Reset mid-operation SHALL drop all queued, in-flight and pending results without emitting any.

Verification
REQ-035 Reset, then push (3F80,4000); model adder pulses adder_ready, returns 4040 -> add_a=3F80 and add_b=4000 after the first event; res_data=4040, res_tag=0 after the second event.
REQ-036 Push 4 pairs with res_ready=0, OUT_DEPTH=2 -> at most 2 results stored; no issue occurs while results(2)+inflight would exceed 2; raising res_ready drains tags 0..3 in order.
REQ-037 Push 5 pairs back-to-back with no events -> in_ready=0 after the 4th push; 5th pair is held off; in_ready returns 1 on the cycle after the first issue.
REQ-038 adder_ready held high for 3 cycles -> exactly one issue and one result write.
REQ-039 Assert nreset while inflight=1 and 1 result is pending -> res_valid=0 and busy=0 immediately; the next event writes no result.
REQ-040 Issue 257 pairs -> tags run 0..255 then 0; no result is lost or duplicated.
